a_rd_cross_xn_ram: RTL and testbench
====================================

Name: a_rd_cross_xn_ram

Overview:
Parametrised N-way RAM read-return crossbar, the successor to the 2:1 combinational read mux. It selects one of NB_CH read-data channels and buffers the selected channel's valid words in a first-word-fall-through FIFO. The FIFO drains to the consumer under a valid/ready handshake. Select changes go through a guard interval so words from the old and new sources never interleave. It sits between the emulation RAM banks and the control/verification read path.

Parameters:
NB_CH, 4, number of input read channels (2..16)
DATA_W, 16, data width per channel
SEL_W, 2, select width; integrator sets it to >= clog2(NB_CH)
DEPTH, 8, FIFO depth in words; power of two, >= 2
GUARD, 1, dead cycles inserted after a select change (>= 1)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_n_i  in  1  asynchronous active-low reset
sel_i  in  SEL_W  requested source channel
data_i  in  NB_CH*DATA_W  packed channel data, channel k at [k*DATA_W +: DATA_W]
dv_i  in  NB_CH  per-channel data valid
data_o  out  DATA_W  FIFO head word
dv_o  out  1  FIFO non-empty (head valid)
rdy_i  in  1  consumer ready; pop when dv_o && rdy_i
full_o  out  1  FIFO holds DEPTH words
empty_o  out  1  FIFO holds 0 words
level_o  out  clog2(DEPTH)+1  current occupancy
cur_sel_o  out  SEL_W  channel currently in effect
ovf_o  out  1  sticky overflow flag
clr_ovf_i  in  1  synchronous clear of ovf_o

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n_i), asserted at any time, released synchronously by the integrator.
- Reset values: data_o=0, dv_o=0, full_o=0, empty_o=1, level_o=0, cur_sel_o=0, ovf_o=0, FSM=ACTIVE, guard counter=0.
- Reset mid-operation: FIFO contents are discarded immediately and all outputs return to their reset values.
- FSM states: ACTIVE and SWITCH.
- ACTIVE, sel_i == cur_sel:
  - push when dv_i[cur_sel] is 1, writing data_i of cur_sel.
  - if cur_sel >= NB_CH, no channel is selected and nothing is pushed.
- ACTIVE, sel_i != cur_sel:
  - no push this cycle.
  - cur_sel <= sel_i, guard counter <= GUARD, next state SWITCH.
- SWITCH:
  - no push.
  - guard counter decrements each cycle; when it reaches 0, next state is ACTIVE.
  - if sel_i differs from cur_sel during SWITCH, cur_sel <= sel_i and the counter reloads to GUARD.
- Total dead input cycles per select change = 1 + GUARD.
- Words presented during dead cycles are discarded and do not set ovf_o.
- FIFO behaviour:
  - first-word-fall-through: data_o is the head word, dv_o = !empty_o.
  - latency: a word pushed into an empty FIFO at edge t is visible at data_o/dv_o after edge t (one cycle).
  - pop when dv_o && rdy_i; head advances at the next edge.
  - data_o is held stable while dv_o=1 and rdy_i=0.
  - while empty, data_o holds its last value; don't-care.
- Boundary conditions:
  - push and pop in the same cycle: level unchanged; allowed when full (new word accepted).
  - push while full without a pop: word dropped, ovf_o <= 1.
  - pop while empty: impossible, since dv_o=0.
  - pointers wrap modulo DEPTH; level_o counts 0..DEPTH.
  - full_o = (level == DEPTH); empty_o = (level == 0); all registered, updated at the same edge as level.
- ovf_o:
  - sticky; cleared when clr_ovf_i=1.
  - if a set and a clear occur in the same cycle, set wins.
- dv_i bits of unselected channels are ignored.
- X on unselected data_i must not propagate to data_o.

Test Plan:
- Basic path: reset, sel_i=2, dv_i[2] pulsed with 0x1234 then 0xBEEF, rdy_i=1 -> dv_o high one cycle after each push; data_o=0x1234 then 0xBEEF; level_o peaks at 1; other dv_i toggling with 0xDEAD never appears at data_o.
- Fill and overflow: rdy_i=0, push 9 words 0x0001..0x0009 on ch0 (DEPTH=8) -> full_o=1 after the 8th; 0x0009 dropped; ovf_o=1. Then rdy_i=1 -> 0x0001..0x0008 out in order, empty_o=1. clr_ovf_i -> ovf_o=0.
- Push/pop when full: FIFO full, rdy_i=1, push 0x00AA in the same cycle -> level stays 8, ovf_o stays 0, 0x00AA emerges last.
- Select switch: ch0 and ch1 both streaming every cycle, sel_i 0->1 at cycle t, GUARD=1 -> ch0 words pushed through t-1; no push at t or t+1; ch1 pushed from t+2; cur_sel_o=1 after edge t; ovf_o unchanged.
- Re-select during SWITCH: sel_i 0->1 at t, 1->3 at t+1 -> guard reloads; first push from ch3 at t+3; no ch1 word ever in the FIFO.
- Async reset mid-stream: 5 words buffered, rst_n_i low mid-cycle -> dv_o=0, level_o=0, cur_sel_o=0 immediately, without waiting for a clock edge; after release, the next ch0 push is the only word output.

Source files
------------

// File: rtl/a_rd_cross_xn_ram.sv
// Purpose : N-way read-return crossbar; the selected channel's valid words are buffered in a FWFT FIFO.
// Latency : a word pushed into an empty FIFO appears on data_o/dv_o one cycle later.
// Backpr. : the consumer stalls with rdy_i=0; a push into a full FIFO without a pop is dropped and sets ovf_o.
//
// Ports:
//   clk_i, rst_n_i         clock, asynchronous active-low reset
//   sel_i, data_i, dv_i    requested channel, packed channel data, per-channel valid
//   data_o, dv_o, rdy_i    FIFO head word, head valid, consumer ready (pop on dv_o && rdy_i)
//   full_o, empty_o        registered occupancy flags
//   level_o                current occupancy
//   cur_sel_o              channel currently in effect
//   ovf_o, clr_ovf_i       sticky overflow flag and its synchronous clear

// Purpose : generic first-word-fall-through FIFO with registered level/full/empty flags.
// Latency : a write at edge t is visible on head_dat after edge t.
// Backpr. : a write while full is accepted only together with a pop; otherwise it is ignored.
module a_rd_cross_xn_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_vld,
  input  logic [DW-1:0]            push_dat,
  input  logic                     pop_rdy,
  output logic [DW-1:0]            head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, empty_q;
  logic          wr, rd;

  // A write into a full FIFO lands in the slot being vacated by the same-cycle pop.
  assign rd = pop_rdy && !empty_q;
  assign wr = push_vld && (!full_q || rd);

  always_comb begin
    level_d = level_q;
    case ({wr, rd})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Memory is cleared on reset so the head reads 0 out of reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (rd) rd_ptr <= rd_ptr + PW'(1);
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH));
      empty_q <= (level_d == LW'(0));
    end
  end

  assign head_dat = mem[rd_ptr];
  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
endmodule

module a_rd_cross_xn_ram #(
  parameter int NB_CH  = 4,
  parameter int DATA_W = 16,
  parameter int SEL_W  = 2,
  parameter int DEPTH  = 8,
  parameter int GUARD  = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [SEL_W-1:0]        sel_i,
  input  logic [NB_CH*DATA_W-1:0] data_i,
  input  logic [NB_CH-1:0]        dv_i,
  output logic [DATA_W-1:0]       data_o,
  output logic                    dv_o,
  input  logic                    rdy_i,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic [SEL_W-1:0]        cur_sel_o,
  output logic                    ovf_o,
  input  logic                    clr_ovf_i
);
  localparam int GW = (GUARD > 1) ? $clog2(GUARD + 1) : 1;

  typedef enum logic {ACTIVE, SWITCH} state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  cur_sel_q, cur_sel_d;
  logic [GW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] ch_dat;
  logic              ch_vld;
  logic              push_vld;
  logic              pop_rdy;
  logic              ovf_q;
  logic              ovf_set;

  // Only the channel in effect is looked at, so X or junk on other channels
  // never reaches the FIFO. An out-of-range select matches no channel.
  always_comb begin
    ch_dat = '0;
    ch_vld = 1'b0;
    for (int k = 0; k < NB_CH; k++) begin
      if (cur_sel_q == SEL_W'(k)) begin
        ch_dat = data_i[k*DATA_W +: DATA_W];
        ch_vld = dv_i[k];
      end
    end
  end

  // Select guard: the change cycle plus GUARD cycles are dead, and any further
  // change while switching restarts the guard, so sources never interleave.
  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    cnt_d     = cnt_q;
    push_vld  = 1'b0;
    case (state_q)
      ACTIVE: begin
        if (sel_i != cur_sel_q) begin
          cur_sel_d = sel_i;
          cnt_d     = GW'(GUARD);
          state_d   = SWITCH;
        end else begin
          push_vld  = ch_vld;
        end
      end
      SWITCH: begin
        if (sel_i != cur_sel_q) begin
          cur_sel_d = sel_i;
          cnt_d     = GW'(GUARD);
        end else begin
          cnt_d = cnt_q - GW'(1);
          if (cnt_q == GW'(1)) state_d = ACTIVE;
        end
      end
      default: state_d = ACTIVE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ACTIVE;
      cur_sel_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pop_rdy = dv_o && rdy_i;
  assign ovf_set = push_vld && full_o && !pop_rdy;

  // Set has priority over a same-cycle clear so no overflow event is lost.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)       ovf_q <= 1'b0;
    else if (ovf_set)   ovf_q <= 1'b1;
    else if (clr_ovf_i) ovf_q <= 1'b0;
  end

  a_rd_cross_xn_fifo #(
    .DW    (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .push_vld (push_vld),
    .push_dat (ch_dat),
    .pop_rdy  (pop_rdy),
    .head_dat (data_o),
    .full     (full_o),
    .empty    (empty_o),
    .level    (level_o)
  );

  assign dv_o      = !empty_o;
  assign cur_sel_o = cur_sel_q;
  assign ovf_o     = ovf_q;
endmodule

// File: tb/tb_a_rd_cross_xn_ram.sv
// Purpose : self-checking bench for a_rd_cross_xn_ram against a queue-based reference model.
// Latency : model expects a pushed word at the head one cycle after its push edge.
// Backpr. : rdy_i driven directed and random; overflow/drop expectations come from the model.
module tb_a_rd_cross_xn_ram;
  localparam int NB_CH  = 4;
  localparam int DATA_W = 16;
  localparam int SEL_W  = 2;
  localparam int DEPTH  = 8;
  localparam int GUARD  = 1;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic                    clk_i = 1'b0;
  logic                    rst_n_i;
  logic [SEL_W-1:0]        sel_i;
  logic [NB_CH*DATA_W-1:0] data_i;
  logic [NB_CH-1:0]        dv_i;
  logic [DATA_W-1:0]       data_o;
  logic                    dv_o;
  logic                    rdy_i;
  logic                    full_o;
  logic                    empty_o;
  logic [LW-1:0]           level_o;
  logic [SEL_W-1:0]        cur_sel_o;
  logic                    ovf_o;
  logic                    clr_ovf_i;

  a_rd_cross_xn_ram #(
    .NB_CH(NB_CH), .DATA_W(DATA_W), .SEL_W(SEL_W), .DEPTH(DEPTH), .GUARD(GUARD)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .sel_i(sel_i), .data_i(data_i), .dv_i(dv_i),
    .data_o(data_o), .dv_o(dv_o), .rdy_i(rdy_i), .full_o(full_o), .empty_o(empty_o),
    .level_o(level_o), .cur_sel_o(cur_sel_o), .ovf_o(ovf_o), .clr_ovf_i(clr_ovf_i)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: expected FIFO contents, sticky flag, the select in effect,
  // and the last GUARD+1 requested selects (a push needs the request to have
  // been constant over those cycles and the current one).
  logic [DATA_W-1:0] exp_q[$];
  logic [SEL_W-1:0]  sel_hist[$];
  logic              m_ovf;
  logic [SEL_W-1:0]  m_cur_sel;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    sel_hist.delete();
    for (int i = 0; i < GUARD + 1; i++) sel_hist.push_back('0);
    m_ovf     = 1'b0;
    m_cur_sel = '0;
  endtask

  task automatic check_outputs();
    chk("dv_o",      32'(dv_o),      32'(exp_q.size() > 0));
    chk("level_o",   32'(level_o),   32'(exp_q.size()));
    chk("full_o",    32'(full_o),    32'(exp_q.size() == DEPTH));
    chk("empty_o",   32'(empty_o),   32'(exp_q.size() == 0));
    chk("ovf_o",     32'(ovf_o),     32'(m_ovf));
    chk("cur_sel_o", 32'(cur_sel_o), 32'(m_cur_sel));
    if (exp_q.size() > 0) chk("data_o", 32'(data_o), 32'(exp_q[0]));
  endtask

  // One clock cycle: predict from the inputs driven now, clock, then compare.
  task automatic cycle();
    bit                ok, push, pop, ovf_set;
    int                s;
    logic [DATA_W-1:0] w;
    s  = int'(sel_i);
    ok = 1'b1;
    foreach (sel_hist[i]) if (sel_hist[i] != sel_i) ok = 1'b0;
    push = ok && (s < NB_CH) && dv_i[s];
    w    = data_i[s*DATA_W +: DATA_W];
    pop  = (exp_q.size() > 0) && rdy_i;
    @(posedge clk_i);
    #1;
    ovf_set = 1'b0;
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(w);
      else ovf_set = 1'b1;
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (clr_ovf_i) m_ovf = 1'b0;
    sel_hist.push_back(sel_i);
    void'(sel_hist.pop_front());
    m_cur_sel = sel_i;
    check_outputs();
  endtask

  task automatic set_ch(input int k, input logic [DATA_W-1:0] v);
    data_i[k*DATA_W +: DATA_W] = v;
  endtask

  task automatic idle(input int n);
    dv_i = '0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Push one word on channel ch while other channels carry 0xDEAD with valid set.
  task automatic push_word(input int ch, input logic [DATA_W-1:0] v);
    for (int k = 0; k < NB_CH; k++) set_ch(k, 16'hDEAD);
    set_ch(ch, v);
    dv_i = '1;
    cycle();
    dv_i = '0;
  endtask

  initial begin
    rst_n_i   = 1'b0;
    sel_i     = '0;
    data_i    = '0;
    dv_i      = '0;
    rdy_i     = 1'b0;
    clr_ovf_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst data_o", 32'(data_o), 32'h0);
    check_outputs();
    rst_n_i = 1'b1;

    // Basic path on channel 2.
    sel_i = 2; rdy_i = 1'b1;
    idle(3);
    push_word(2, 16'h1234);
    idle(1);
    push_word(2, 16'hBEEF);
    idle(2);

    // Fill and overflow on channel 0, then drain and clear.
    sel_i = 0; rdy_i = 1'b0;
    idle(3);
    for (int i = 1; i <= 9; i++) push_word(0, 16'(i));
    rdy_i = 1'b1;
    idle(9);
    clr_ovf_i = 1'b1; idle(1); clr_ovf_i = 1'b0;

    // Push and pop together while full.
    rdy_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_word(0, 16'h0010 + 16'(i));
    rdy_i = 1'b1;
    push_word(0, 16'h00AA);
    rdy_i = 1'b0;
    // Overflow and clear in the same cycle: set wins.
    clr_ovf_i = 1'b1; push_word(0, 16'h00BB); clr_ovf_i = 1'b0;
    rdy_i = 1'b1;
    idle(9);
    clr_ovf_i = 1'b1; idle(1); clr_ovf_i = 1'b0;

    // Select switch with ch0 and ch1 streaming every cycle.
    dv_i = '1;
    for (int i = 0; i < 8; i++) begin
      sel_i = (i < 3) ? 2'd0 : 2'd1;
      set_ch(0, 16'h0A00 + 16'(i));
      set_ch(1, 16'h0B00 + 16'(i));
      set_ch(3, 16'h0D00 + 16'(i));
      cycle();
    end
    // Re-select during SWITCH: 1 -> 0 -> 3.
    for (int i = 0; i < 8; i++) begin
      sel_i = (i == 0) ? 2'd0 : 2'd3;
      set_ch(0, 16'h1A00 + 16'(i));
      set_ch(1, 16'h1B00 + 16'(i));
      set_ch(3, 16'h1D00 + 16'(i));
      cycle();
    end
    sel_i = 0;
    idle(DEPTH + 4);

    // Asynchronous reset mid-stream with 5 words buffered.
    rdy_i = 1'b0;
    for (int i = 0; i < 5; i++) push_word(0, 16'h0C00 + 16'(i));
    sel_i = 1;
    #2 rst_n_i = 1'b0;
    #1;
    chk("arst dv_o",      32'(dv_o),      32'h0);
    chk("arst level_o",   32'(level_o),   32'h0);
    chk("arst cur_sel_o", 32'(cur_sel_o), 32'h0);
    model_reset();
    sel_i = 0;
    @(posedge clk_i);
    #1;
    check_outputs();
    rst_n_i = 1'b1;
    rdy_i = 1'b1;
    push_word(0, 16'h5A5A);
    idle(3);

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) sel_i = SEL_W'($urandom_range(0, NB_CH - 1));
      for (int k = 0; k < NB_CH; k++) set_ch(k, DATA_W'($urandom));
      dv_i      = NB_CH'($urandom);
      rdy_i     = ($urandom_range(0, 3) != 0) ? ((i / 50) % 2 == 0) : ((i / 50) % 2 != 0);
      clr_ovf_i = ($urandom_range(0, 15) == 0);
      cycle();
    end
    clr_ovf_i = 1'b0;
    rdy_i = 1'b1;
    idle(DEPTH + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
